edge_propagator_rx_mc: RTL
==========================

EDGE_PROPAGATOR_RX_MC -- requirements
Module: edge_propagator_rx_mc

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent channels; legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flop depth per channel; legal range 2..4.
REQ-003 Parameter EDGE_MODE, default 0, edge detection mode: 0 rising, 1 falling, 2 both.
REQ-004 clk_i  input  1  single receive-domain clock, all flops on rising edge.
REQ-005 rstn_i  input  1  reset; one clock, reset is synchronous and active-low.
REQ-006 valid_i  input  NUM_CH  asynchronous level per channel from the transmit domain.
REQ-007 ack_o  output  NUM_CH  synchronized copy of valid_i (last sync stage), returned to transmitter.
REQ-008 valid_o  output  NUM_CH  single-cycle pulse per detected edge.
REQ-009 evt_valid_o  output  NUM_CH  per-channel pending-event flag (valid/ready source).
REQ-010 evt_ready_i  input  NUM_CH  per-channel consumer ready.
REQ-011 ovf_o  output  NUM_CH  sticky per-channel overflow flag.
REQ-012 ovf_clr_i  input  1  clears all ovf_o bits.

Function
REQ-013 Each channel SHALL contain SYNC_STAGES flops in series (sync[0] samples valid_i) plus one history flop prev holding the previous sync[SYNC_STAGES-1].
REQ-014 ack_o[c] SHALL equal sync[SYNC_STAGES-1] of channel c, registered, no combinational path from valid_i.
REQ-015 Detected edge: mode 0 sync_last & ~prev; mode 1 ~sync_last & prev; mode 2 sync_last ^ prev.
REQ-016 valid_o[c] SHALL be combinational from the detected edge of channel c and high for exactly one cycle per edge.
REQ-017 Latency: valid_i change sampled at edge E1 SHALL raise valid_o in the cycle after edge E_SYNC_STAGES, and ack_o updates at E_SYNC_STAGES.
REQ-018 Pending flag: edge detected at edge E SHALL set evt_valid_o at E+1 (registered from valid_o).
REQ-019 Handshake: evt_valid_o & evt_ready_i at an edge SHALL clear the flag, unless a new edge is detected in that same cycle, in which case flag stays 1 and no overflow.
REQ-020 Edge detected while evt_valid_o=1 and evt_ready_i=0 SHALL set ovf_o[c] at next edge; flag stays 1 (events merge, not queued).
REQ-021 evt_valid_o SHALL not depend combinationally on evt_ready_i; ready may be asserted without valid (no effect).
REQ-022 ovf_clr_i=1 SHALL clear all ovf_o bits at next edge; simultaneous set on a channel wins over clear.
REQ-023 Channels SHALL be fully independent; activity on one channel SHALL not alter another's outputs.
REQ-024 In mode 2 two edges toggling within fewer cycles than the sync chain SHALL each still produce a pulse if each level is held >= 1 clk period; shorter glitches may be lost (no requirement).

Reset
REQ-025 While rstn_i=0 at an edge, all sync, prev, evt_valid_o and ovf_o bits SHALL become 0; valid_o and ack_o read 0 from the next cycle.
REQ-026 Reset SHALL dominate evt_ready_i, ovf_clr_i and detected edges in the same cycle.
REQ-027 If valid_i is 1 when reset releases, modes 0 and 2 SHALL report one rising edge after SYNC_STAGES cycles; mode 1 SHALL report none.
REQ-028 Reset asserted mid-operation SHALL drop pending events and overflow without producing a pulse.

Verification
REQ-029 NUM_CH=4, SYNC_STAGES=2, mode 0: valid_i[1] 0->1 before E1 -> ack_o[1]=1 after E2, valid_o[1] pulses one cycle after E2, evt_valid_o[1]=1 after E3, other channels all 0.
REQ-030 Mode 2, valid_i[0] 0->1 then 1->0 ten cycles later, evt_ready_i=1 -> two valid_o[0] pulses 10 cycles apart, evt_valid_o[0] high one cycle each, ovf_o=0.
REQ-031 Mode 0, evt_ready_i=0, two rising edges on channel 2 -> evt_valid_o[2]=1 held, ovf_o[2]=1 after second edge; ovf_clr_i pulse -> ovf_o=0, evt_valid_o[2] still 1.
REQ-032 Pending with evt_ready_i=1 in the same cycle valid_o pulses -> evt_valid_o stays 1, ovf_o stays 0; next cycle ready -> 0.
REQ-033 SYNC_STAGES=3, valid_i=4'hF at reset release -> valid_o=4'hF pulse in cycle after third edge in mode 0; none in mode 1.
REQ-034 rstn_i low while evt_valid_o=4'hA and ovf_o=4'h2 -> both 0 after one edge, no valid_o pulse.

Source files
------------

// File: rtl/edge_propagator_rx_mc.sv
// Multi-channel receive-side level synchronizer with edge pulses and a per-channel pending/overflow flag.
// Edge pulse follows the input change by SYNC_STAGES clocks; ready never stalls capture, and unserviced events merge into the overflow flag.
module edge_propagator_rx_mc #(
   parameter int NUM_CH      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_MODE   = 0
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic [NUM_CH-1:0] valid_i,
   output logic [NUM_CH-1:0] ack_o,
   output logic [NUM_CH-1:0] valid_o,
   output logic [NUM_CH-1:0] evt_valid_o,
   input  logic [NUM_CH-1:0] evt_ready_i,
   output logic [NUM_CH-1:0] ovf_o,
   input  logic              ovf_clr_i
);

   localparam int MODE_RISE = 0;
   localparam int MODE_FALL = 1;

   logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
   logic [NUM_CH-1:0]      sync_last;
   logic [NUM_CH-1:0]      prev_q;
   logic [NUM_CH-1:0]      edge_det;
   logic [NUM_CH-1:0]      evt_q;
   logic [NUM_CH-1:0]      ovf_q;
   logic [NUM_CH-1:0]      evt_take;

   always_comb begin
      sync_last = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         sync_last[c] = sync_q[c][SYNC_STAGES-1];
      end
   end

   generate
      if (EDGE_MODE == MODE_RISE) begin : g_rise
         assign edge_det = sync_last & ~prev_q;
      end else if (EDGE_MODE == MODE_FALL) begin : g_fall
         assign edge_det = ~sync_last & prev_q;
      end else begin : g_both
         assign edge_det = sync_last ^ prev_q;
      end
   endgenerate

   // A fresh edge always wins: it keeps the flag set even when the consumer takes the old one.
   assign evt_take = evt_q & evt_ready_i;

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         for (int c = 0; c < NUM_CH; c++) begin
            sync_q[c] <= '0;
         end
         prev_q <= '0;
         evt_q  <= '0;
         ovf_q  <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], valid_i[c]};
         end
         prev_q <= sync_last;
         evt_q  <= edge_det | (evt_q & ~evt_take);
         ovf_q  <= (edge_det & evt_q & ~evt_ready_i) | (ovf_q & ~{NUM_CH{ovf_clr_i}});
      end
   end

   assign ack_o       = sync_last;
   assign valid_o     = edge_det;
   assign evt_valid_o = evt_q;
   assign ovf_o       = ovf_q;

endmodule
